codificador_pt2262: RTL and testbench

- Encoder stage directly downstream of the system oscillator; consumes its ~12 kHz `osc` square wave as the timing base α (one α = one osc period).
- Produces the PT2262-compatible serial code word on `dout`, which feeds the RF/line driver and, in loopback, the decoder.
- Each frame is 12 tri-state symbols followed by one sync bit; frames repeat while transmission is enabled, with a minimum burst of 4 frames.

---
 rtl/codificador_pt2262.sv | 159 +++++++++++++++
 tb/tb_codificador_pt2262.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/codificador_pt2262.sv
// codificador_pt2262: PT2262-compatible serial encoder.
// Each frame is NSYM tri-state symbols of 32 alpha followed by a 128-alpha sync bit.
// One alpha is one period of the osc input.
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   osc          oscillator square wave, synchronous to clk; its rising edge is the alpha tick
//   te           transmit enable (level)
//   sym          2 bits per symbol, MSB pair sent first (00='0', 01='1', 1x='F')
//   dout         encoded serial output
//   busy         high while a frame is in progress
//   frame_done   one-clk pulse at the end of every sync bit
//   frames_sent  completed frames since reset (wraps)
module codificador_pt2262 #(
    parameter int unsigned NSYM       = 12,
    parameter int unsigned MIN_FRAMES = 4,
    parameter int unsigned NARROW     = 4,
    parameter int unsigned WIDE       = 12,
    parameter int unsigned SYNC_HIGH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                osc,
    input  logic                te,
    input  logic [2*NSYM-1:0]   sym,
    output logic                dout,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          frames_sent
);

    localparam int unsigned SW   = 2 * NSYM;
    localparam int unsigned IDXW = (NSYM > 1) ? $clog2(NSYM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BITS = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    state_t            state;
    logic              osc_d;
    logic [SW-1:0]     shreg;
    logic [IDXW-1:0]   idx;
    logic [4:0]        a;
    logic [6:0]        s;
    logic [7:0]        burst;

    logic              tick;
    logic [7:0]        burst_inc;
    logic              more_frames;

    // Pulse width (in alpha) of half h of a symbol with code c.
    function automatic logic [4:0] width_of(input logic [1:0] c, input logic h);
        logic [4:0] w;
        case (c)
            2'b00:   w = 5'(NARROW);
            2'b01:   w = 5'(WIDE);
            default: w = h ? 5'(WIDE) : 5'(NARROW);
        endcase
        return w;
    endfunction

    // Output level for symbol c at alpha position pos within the symbol.
    function automatic logic bit_level(input logic [1:0] c, input logic [4:0] pos);
        return {1'b0, pos[3:0]} < width_of(c, pos[4]);
    endfunction

    function automatic logic sync_level(input logic [6:0] pos);
        return pos < 7'(SYNC_HIGH);
    endfunction

    // Alpha tick; osc_d resets high so a high osc at reset release is not a tick.
    assign tick        = osc & ~osc_d;
    assign burst_inc   = (burst == 8'hFF) ? burst : burst + 8'd1;
    assign more_frames = te || (burst_inc < 8'(MIN_FRAMES));

    // Encoder state machine; everything advances on alpha ticks only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            osc_d       <= 1'b1;
            shreg       <= '0;
            idx         <= '0;
            a           <= '0;
            s           <= '0;
            burst       <= '0;
            dout        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
        end else begin
            osc_d      <= osc;
            frame_done <= 1'b0;
            if (tick) begin
                unique case (state)
                    ST_IDLE: begin
                        if (te) begin
                            shreg <= sym;
                            burst <= '0;
                            idx   <= '0;
                            a     <= '0;
                            state <= ST_BITS;
                            busy  <= 1'b1;
                            dout  <= bit_level(sym[SW-1 -: 2], 5'd0);
                        end else begin
                            dout <= 1'b0;
                        end
                    end
                    ST_BITS: begin
                        if (a == 5'd31) begin
                            a <= '0;
                            if (idx == IDXW'(NSYM - 1)) begin
                                s     <= '0;
                                state <= ST_SYNC;
                                dout  <= sync_level(7'd0);
                            end else begin
                                idx   <= idx + IDXW'(1);
                                shreg <= shreg << 2;
                                dout  <= bit_level(shreg[SW-3 -: 2], 5'd0);
                            end
                        end else begin
                            a    <= a + 5'd1;
                            dout <= bit_level(shreg[SW-1 -: 2], a + 5'd1);
                        end
                    end
                    ST_SYNC: begin
                        if (s == 7'd127) begin
                            frame_done  <= 1'b1;
                            frames_sent <= frames_sent + 8'd1;
                            burst       <= burst_inc;
                            // Next frame follows with no gap while requested or below the minimum burst.
                            if (more_frames) begin
                                shreg <= sym;
                                idx   <= '0;
                                a     <= '0;
                                state <= ST_BITS;
                                dout  <= bit_level(sym[SW-1 -: 2], 5'd0);
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                dout  <= 1'b0;
                            end
                        end else begin
                            s    <= s + 7'd1;
                            dout <= sync_level(s + 7'd1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        dout  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_codificador_pt2262.sv
// tb_codificador_pt2262: directed bench for the PT2262 encoder.
// Expected dout per alpha is queued when a burst is launched and popped once per alpha.
module tb_codificador_pt2262;

    logic        clk;
    logic        rst;
    logic        osc;
    logic        te;
    logic [23:0] sym;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frames_sent;

    int  vectors;
    int  miscompares;
    int  fd_cnt;
    int  fs_exp;
    int  ph;
    bit  osc_run;
    bit  exp_q[$];
    bit  mon_e;
    bit  last_exp;

    codificador_pt2262 dut (
        .clk         (clk),
        .rst         (rst),
        .osc         (osc),
        .te          (te),
        .sym         (sym),
        .dout        (dout),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-clk oscillator: high for phases 0..3, rising edge entering phase 0.
    initial begin
        osc = 1'b1;
        ph  = 1;
        forever begin
            @(posedge clk);
            #1;
            if (osc_run) begin
                ph  = (ph == 7) ? 0 : ph + 1;
                osc = (ph < 4);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // dout is sampled once per alpha, one clk after the DUT sees the rising osc edge.
    always @(negedge clk) begin
        if (osc_run && ph == 1) begin
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else                  mon_e = 1'b0;
            last_exp = mon_e;
            check("dout", 32'(dout), 32'(mon_e));
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic push_frame(input logic [23:0] code);
        for (int i = 0; i < 12; i++) begin
            logic [1:0] c;
            c = code[23 - 2*i -: 2];
            for (int k = 0; k < 32; k++) begin
                int w;
                if (c == 2'b00)      w = 4;
                else if (c == 2'b01) w = 12;
                else                 w = (k < 16) ? 4 : 12;
                exp_q.push_back((k % 16) < w);
            end
        end
        for (int k = 0; k < 128; k++) exp_q.push_back(k < 4);
    endtask

    // Advance n alpha periods, returning at the mid-period negedge (osc low).
    task automatic wait_alpha(input int n);
        repeat (n) begin
            do @(negedge clk); while (ph != 4);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fd_cnt      = 0;
        fs_exp      = 0;
        osc_run     = 1'b0;
        rst         = 1'b0;
        te          = 1'b0;
        sym         = '0;

        // Reset with osc held high: no tick on release.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_dout",        32'(dout),        32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        check("rst_frame_done",  32'(frame_done),  32'd0);
        osc_run = 1'b1;
        wait_alpha(4);
        check("idle_busy", 32'(busy), 32'd0);

        // One-alpha te pulse, all '0': minimum burst of 4 frames, with an osc stall mid-frame.
        wait_alpha(1);
        te  = 1'b1;
        sym = 24'h000000;
        for (int f = 0; f < 4; f++) push_frame(24'h000000);
        fs_exp += 4;
        wait_alpha(1);
        te = 1'b0;
        wait_alpha(2);
        check("burst_busy", 32'(busy), 32'd1);
        wait_alpha(94);
        osc_run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (10) @(negedge clk);
            check("stall_dout", 32'(dout), 32'(last_exp));
            check("stall_busy", 32'(busy), 32'd1);
        end
        osc_run = 1'b1;
        wait_alpha(4*512 - 96 + 20);
        check("b0_frames_sent", 32'(frames_sent), 32'(fs_exp));
        check("b0_frame_done",  32'(fd_cnt),      32'd4);
        check("b0_busy",        32'(busy),        32'd0);

        // te held for 10 frames; sym switches from all '1' to all 'F' during frame 3.
        fd_cnt = 0;
        wait_alpha(1);
        te  = 1'b1;
        sym = 24'h555555;
        for (int f = 0; f < 3; f++)  push_frame(24'h555555);
        for (int f = 3; f < 10; f++) push_frame(24'hAAAAAA);
        fs_exp += 10;
        wait_alpha(1);
        wait_alpha(1124);
        sym = 24'hAAAAAA;
        wait_alpha(3584);
        te = 1'b0;
        wait_alpha(432);
        check("b10_frames_sent", 32'(frames_sent), 32'(fs_exp));
        check("b10_frame_done",  32'(fd_cnt),      32'd10);
        check("b10_busy",        32'(busy),        32'd0);
        check("b10_queue",       32'(exp_q.size()), 32'd0);

        // Reset at alpha 200 of frame 2 (symbol '1', dout high there).
        fd_cnt = 0;
        wait_alpha(1);
        te  = 1'b1;
        sym = 24'h555555;
        for (int f = 0; f < 4; f++) push_frame(24'h555555);
        wait_alpha(1);
        te = 1'b0;
        wait_alpha(712);
        fs_exp += 1;
        check("pre_rst_frames_sent", 32'(frames_sent), 32'(fs_exp));
        check("pre_rst_dout",        32'(dout),        32'd1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        fs_exp = 0;
        #1;
        check("mid_rst_dout",        32'(dout),        32'd0);
        check("mid_rst_busy",        32'(busy),        32'd0);
        check("mid_rst_frames_sent", 32'(frames_sent), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_alpha(600);
        check("post_rst_busy",        32'(busy),        32'd0);
        check("post_rst_frames_sent", 32'(frames_sent), 32'd0);
        check("post_rst_frame_done",  32'(fd_cnt),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
